// File: rtl/motor_pkg.sv
// Shared types and helpers for the N-channel PWM H-bridge driver.
package motor_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DEAD} ch_state_t;

   function automatic int sat_duty(input int count, input int period);
      return (count > period) ? period : count;
   endfunction

   // Move cur toward tgt by at most step, landing exactly on tgt when close enough.
   function automatic int ramp_toward(input int cur, input int tgt, input int step);
      if (tgt > cur) return ((tgt - cur) > step) ? cur + step : tgt;
      return ((cur - tgt) > step) ? cur - step : tgt;
   endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// One PWM H-bridge channel: shadowed command, IDLE/RUN/DEAD FSM and registered pins.
// MOTOR_RAMP_EN enables per-period duty ramping (bounded by RAMP_STEP).
module motor_pwm_channel
   import motor_pkg::*;
#(
   parameter int DUTY_W    = 7,
   parameter int PERIOD    = 100,
   parameter int DEADTIME  = 2,
   parameter int RAMP_STEP = 5,
   parameter int CNT_W     = 7
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_tick,
   input  logic              i_boundary,
   input  logic [CNT_W-1:0]  i_pwmCnt,
   input  logic              i_cmdValid,
   input  logic              i_cmdSign,
   input  logic [DUTY_W-1:0] i_cmdCount,
   output logic              o_enable,
   output logic              o_inA,
   output logic              o_inB
);

   localparam int DEAD_W = $clog2(DEADTIME + 1);
`ifdef MOTOR_RAMP_EN
   localparam bit RAMP_EN = 1'b1;
`else
   localparam bit RAMP_EN = 1'b0;
`endif
   // Without ramping a full-period step makes every duty change immediate.
   localparam int STEP = RAMP_EN ? RAMP_STEP : PERIOD;

   ch_state_t          r_state;
   logic               r_pendSign;
   logic [DUTY_W-1:0]  r_pendDuty;
   logic               r_actSign;
   logic [DUTY_W-1:0]  r_actDuty;
   logic [DEAD_W-1:0]  r_deadCnt;
   logic               r_enable;
   logic               r_inA;
   logic               r_inB;

   ch_state_t          w_nextState;
   logic               w_nextSign;
   logic [DUTY_W-1:0]  w_nextDuty;
   logic [DEAD_W-1:0]  w_nextDead;
   logic               w_update;
   logic [DUTY_W-1:0]  w_cmdSat;
   logic [DUTY_W-1:0]  w_entryDuty;

   // i_boundary flags the last counter slot; the update happens on that slot's tick.
   assign w_update    = i_tick & i_boundary;
   assign w_cmdSat    = DUTY_W'(sat_duty(int'(i_cmdCount), PERIOD));
   assign w_entryDuty = DUTY_W'(sat_duty(int'(r_pendDuty), STEP));

   always_comb begin
      w_nextState = r_state;
      w_nextSign  = r_actSign;
      w_nextDuty  = r_actDuty;
      w_nextDead  = r_deadCnt;
      if (w_update) begin
         case (r_state)
            IDLE: begin
               if (r_pendDuty != '0) begin
                  w_nextState = RUN;
                  w_nextSign  = r_pendSign;
                  w_nextDuty  = w_entryDuty;
               end
            end
            RUN: begin
               if (r_pendSign != r_actSign) begin
                  if (!RAMP_EN || r_actDuty == '0) begin
                     w_nextState = DEAD;
                     w_nextDead  = DEAD_W'(DEADTIME - 1);
                  end else begin
                     w_nextDuty = DUTY_W'(ramp_toward(int'(r_actDuty), 0, STEP));
                  end
               end else if (r_pendDuty == '0 && (!RAMP_EN || r_actDuty == '0)) begin
                  w_nextState = IDLE;
               end else begin
                  w_nextDuty = DUTY_W'(ramp_toward(int'(r_actDuty), int'(r_pendDuty), STEP));
               end
            end
            DEAD: begin
               if (r_deadCnt != '0) begin
                  w_nextDead = r_deadCnt - 1'b1;
               end else if (r_pendDuty == '0) begin
                  w_nextState = IDLE;
               end else begin
                  w_nextState = RUN;
                  w_nextSign  = r_pendSign;
                  w_nextDuty  = w_entryDuty;
               end
            end
            default: ;
         endcase
      end
   end

   // Pins are registered from the current state and counter, giving one clk of latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_pendSign <= 1'b1;
         r_pendDuty <= '0;
         r_actSign  <= 1'b1;
         r_actDuty  <= '0;
         r_deadCnt  <= '0;
         r_enable   <= 1'b0;
         r_inA      <= 1'b0;
         r_inB      <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_actSign <= w_nextSign;
         r_actDuty <= w_nextDuty;
         r_deadCnt <= w_nextDead;
         if (i_cmdValid) begin
            r_pendSign <= i_cmdSign;
            r_pendDuty <= w_cmdSat;
         end
         r_enable <= (r_state == RUN) && (int'(i_pwmCnt) < int'(r_actDuty));
         r_inA    <= (r_state == RUN) && r_actSign;
         r_inB    <= (r_state == RUN) && !r_actSign;
      end
   end

   assign o_enable = r_enable;
   assign o_inA    = r_inA;
   assign o_inB    = r_inB;

endmodule

// File: rtl/motor_pwm_driver.sv
// N-channel PWM H-bridge driver top: prescaler, shared PWM timebase and per-channel instances.
// Optional duty ramping is selected with MOTOR_RAMP_EN (see motor_pwm_channel).
module motor_pwm_driver
   import motor_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int DUTY_W    = 7,
   parameter int PERIOD    = 100,
   parameter int PRESC     = 48,
   parameter int DEADTIME  = 2,
   parameter int RAMP_STEP = 5
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_valid,
   input  logic [NUM_CH-1:0]        motor_sign,
   input  logic [NUM_CH*DUTY_W-1:0] motor_count,
   output logic [NUM_CH-1:0]        enable,
   output logic [NUM_CH-1:0]        in_a,
   output logic [NUM_CH-1:0]        in_b,
   output logic                     period_start
);

   localparam int CNT_W   = $clog2(PERIOD);
   localparam int PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;

   logic [PRESC_W-1:0] r_presc;
   logic [CNT_W-1:0]   r_pwmCnt;
   logic               r_periodStart;
   logic               w_tick;
   logic               w_lastCnt;

   assign w_tick    = (r_presc == PRESC_W'(PRESC - 1));
   assign w_lastCnt = (r_pwmCnt == CNT_W'(PERIOD - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc       <= '0;
         r_pwmCnt      <= '0;
         r_periodStart <= 1'b0;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         if (w_tick) begin
            r_pwmCnt <= w_lastCnt ? '0 : r_pwmCnt + 1'b1;
         end
         r_periodStart <= w_tick & w_lastCnt;
      end
   end

   assign period_start = r_periodStart;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      motor_pwm_channel #(
         .DUTY_W    (DUTY_W),
         .PERIOD    (PERIOD),
         .DEADTIME  (DEADTIME),
         .RAMP_STEP (RAMP_STEP),
         .CNT_W     (CNT_W)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .i_tick     (w_tick),
         .i_boundary (w_lastCnt),
         .i_pwmCnt   (r_pwmCnt),
         .i_cmdValid (cmd_valid),
         .i_cmdSign  (motor_sign[g]),
         .i_cmdCount (motor_count[g*DUTY_W +: DUTY_W]),
         .o_enable   (enable[g]),
         .o_inA      (in_a[g]),
         .o_inB      (in_b[g])
      );
   end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Self-checking bench for motor_pwm_driver: period-level reference model plus directed literal windows.
// Follows MOTOR_RAMP_EN to select the ramping or immediate-step expectations.
module tb_motor_pwm_driver;

   localparam int NUM_CH    = 2;
   localparam int DUTY_W    = 7;
   localparam int PERIOD    = 100;
   localparam int PRESC     = 2;
   localparam int DEADTIME  = 2;
   localparam int RAMP_STEP = 5;
   localparam int WIN       = PERIOD * PRESC;
`ifdef MOTOR_RAMP_EN
   localparam bit RAMP = 1'b1;
`else
   localparam bit RAMP = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     reset = 1'b1;
   logic                     cmd_valid = 1'b0;
   logic [NUM_CH-1:0]        motor_sign = '1;
   logic [NUM_CH*DUTY_W-1:0] motor_count = '0;
   logic [NUM_CH-1:0]        enable;
   logic [NUM_CH-1:0]        in_a;
   logic [NUM_CH-1:0]        in_b;
   logic                     period_start;

   int checks = 0;
   int errors = 0;

   motor_pwm_driver #(
      .NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .PERIOD(PERIOD),
      .PRESC(PRESC), .DEADTIME(DEADTIME), .RAMP_STEP(RAMP_STEP)
   ) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid),
      .motor_sign(motor_sign), .motor_count(motor_count),
      .enable(enable), .in_a(in_a), .in_b(in_b), .period_start(period_start)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   // Reference model: time expressed as a cycle count since reset, channel behaviour per period.
   int mN = 0;
   int mState[NUM_CH];
   int mPendSign[NUM_CH];
   int mPendDuty[NUM_CH];
   int mActSign[NUM_CH];
   int mActDuty[NUM_CH];
   int mDead[NUM_CH];
   logic [NUM_CH-1:0] expEn = '0, expA = '0, expB = '0;
   logic expPs = 1'b0;
   bit modelValid = 1'b0;

   function automatic int minI(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int entryDuty(input int pend);
      return RAMP ? minI(pend, RAMP_STEP) : pend;
   endfunction

   function automatic int towardDuty(input int cur, input int tgt);
      if (!RAMP) return tgt;
      if (tgt > cur) return minI(tgt, cur + RAMP_STEP);
      return (cur - RAMP_STEP > tgt) ? cur - RAMP_STEP : tgt;
   endfunction

   task automatic modelBoundary(input int ch);
      case (mState[ch])
         0: if (mPendDuty[ch] != 0) begin
               mState[ch] = 1; mActSign[ch] = mPendSign[ch]; mActDuty[ch] = entryDuty(mPendDuty[ch]);
            end
         1: if (mPendSign[ch] != mActSign[ch]) begin
               if (RAMP && mActDuty[ch] > 0) mActDuty[ch] = towardDuty(mActDuty[ch], 0);
               else begin mState[ch] = 2; mDead[ch] = DEADTIME - 1; end
            end else if (mPendDuty[ch] == 0 && (!RAMP || mActDuty[ch] == 0)) begin
               mState[ch] = 0;
            end else begin
               mActDuty[ch] = towardDuty(mActDuty[ch], mPendDuty[ch]);
            end
         default: if (mDead[ch] > 0) mDead[ch]--;
            else if (mPendDuty[ch] == 0) mState[ch] = 0;
            else begin
               mState[ch] = 1; mActSign[ch] = mPendSign[ch]; mActDuty[ch] = entryDuty(mPendDuty[ch]);
            end
      endcase
   endtask

   initial forever begin
      @(posedge clk);
      if (reset) begin
         mN = 0; expEn = '0; expA = '0; expB = '0; expPs = 1'b0; modelValid = 1'b1;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            mState[ch] = 0; mPendSign[ch] = 1; mPendDuty[ch] = 0;
            mActSign[ch] = 1; mActDuty[ch] = 0; mDead[ch] = 0;
         end
      end else begin
         int pos, cnt;
         bit bnd;
         pos = mN % PRESC;
         cnt = (mN / PRESC) % PERIOD;
         bnd = (pos == PRESC - 1) && (cnt == PERIOD - 1);
         for (int ch = 0; ch < NUM_CH; ch++) begin
            expEn[ch] = (mState[ch] == 1) && (cnt < mActDuty[ch]);
            expA[ch]  = (mState[ch] == 1) && (mActSign[ch] == 1);
            expB[ch]  = (mState[ch] == 1) && (mActSign[ch] == 0);
         end
         expPs = bnd;
         if (bnd) for (int ch = 0; ch < NUM_CH; ch++) modelBoundary(ch);
         if (cmd_valid) for (int ch = 0; ch < NUM_CH; ch++) begin
            mPendSign[ch] = int'(motor_sign[ch]);
            mPendDuty[ch] = minI(int'(motor_count[ch*DUTY_W +: DUTY_W]), PERIOD);
         end
         mN++;
      end
   end

   // Compare process: model match plus bridge-safety invariants on every cycle.
   logic [NUM_CH-1:0] prevA = '0, prevB = '0, prevEn = '0;
   initial forever begin
      @(negedge clk);
      if (modelValid) begin
         checkOutput($sformatf("model_enable t=%0t", $time), int'(enable), int'(expEn));
         checkOutput($sformatf("model_in_a t=%0t", $time), int'(in_a), int'(expA));
         checkOutput($sformatf("model_in_b t=%0t", $time), int'(in_b), int'(expB));
         checkOutput($sformatf("model_period_start t=%0t", $time), int'(period_start), int'(expPs));
         checkOutput($sformatf("a_and_b t=%0t", $time), int'(in_a & in_b), 0);
         for (int ch = 0; ch < NUM_CH; ch++)
            if (in_a[ch] != prevA[ch] || in_b[ch] != prevB[ch])
               checkOutput($sformatf("pin_change_en ch%0d t=%0t", ch, $time),
                           int'(prevEn[ch] & enable[ch]), 0);
         prevA = in_a; prevB = in_b; prevEn = enable;
      end
   end

   int winHi[NUM_CH], winA[NUM_CH], winB[NUM_CH];
   int winPs;

   task automatic applyStimulus(input logic [NUM_CH-1:0] s, input logic [NUM_CH*DUTY_W-1:0] c);
      @(negedge clk);
      motor_sign = s; motor_count = c; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic waitPeriodStart();
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (period_start !== 1'b1 && k < 3 * WIN);
      if (period_start !== 1'b1) checkOutput("period_start_timeout", 0, 1);
   endtask

   // Samples the outputs belonging to one whole PWM period (they lag the counter by one clk).
   task automatic measureNext();
      winPs = 0;
      for (int ch = 0; ch < NUM_CH; ch++) begin winHi[ch] = 0; winA[ch] = 0; winB[ch] = 0; end
      repeat (WIN) begin
         @(negedge clk);
         winPs += int'(period_start);
         for (int ch = 0; ch < NUM_CH; ch++) begin
            winHi[ch] += int'(enable[ch]); winA[ch] += int'(in_a[ch]); winB[ch] += int'(in_b[ch]);
         end
      end
   endtask

   task automatic checkWin(input string name, input int ch, input int hi, input int a, input int b);
      checkOutput({name, "_enable_clks"}, winHi[ch], hi);
      checkOutput({name, "_in_a_clks"}, winA[ch], a);
      checkOutput({name, "_in_b_clks"}, winB[ch], b);
      checkOutput({name, "_period_starts"}, winPs, 1);
   endtask

   task automatic directedBasic();
      applyStimulus(2'b01, {7'd100, 7'd30});
      waitPeriodStart(); measureNext();
      checkWin("run30_ch0", 0, 30 * PRESC, WIN, 0);
      checkWin("run100_ch1", 1, WIN, 0, WIN);
      applyStimulus(2'b01, {7'd127, 7'd30});
      waitPeriodStart(); measureNext();
      checkWin("sat127_ch1", 1, WIN, 0, WIN);
      applyStimulus(2'b01, {7'd127, 7'd50});
      waitPeriodStart(); measureNext();
      checkWin("run50_ch0", 0, 50 * PRESC, WIN, 0);
      applyStimulus(2'b00, {7'd127, 7'd50});
      waitPeriodStart(); measureNext();
      checkWin("dead1_ch0", 0, 0, 0, 0);
      measureNext();
      checkWin("dead2_ch0", 0, 0, 0, 0);
      measureNext();
      checkWin("reversed_ch0", 0, 50 * PRESC, 0, WIN);
      fork
         measureNext();
         begin
            repeat (20) @(negedge clk);
            applyStimulus(2'b00, {7'd127, 7'd20});
            repeat (20) @(negedge clk);
            applyStimulus(2'b00, {7'd127, 7'd70});
         end
      join
      checkWin("shadow_old_ch0", 0, 50 * PRESC, 0, WIN);
      measureNext();
      checkWin("shadow_new_ch0", 0, 70 * PRESC, 0, WIN);
      repeat (WIN - 2) @(negedge clk);
      applyStimulus(2'b00, {7'd127, 7'd20});
      measureNext();
      checkWin("bnd_cmd_late_ch0", 0, 70 * PRESC, 0, WIN);
      measureNext();
      checkWin("bnd_cmd_applied_ch0", 0, 20 * PRESC, 0, WIN);
      applyStimulus(2'b00, {7'd127, 7'd0});
      waitPeriodStart(); measureNext();
      checkWin("stop_ch0", 0, 0, 0, 0);
      checkWin("still_running_ch1", 1, WIN, 0, WIN);
   endtask

   task automatic directedRamp();
      int upHi[5] = '{10, 20, 30, 40, 46};
      int downHi[5] = '{36, 26, 16, 6, 0};
      applyStimulus(2'b11, {7'd0, 7'd23});
      waitPeriodStart();
      for (int i = 0; i < 4; i++) begin
         measureNext();
         checkWin($sformatf("ramp_up%0d_ch0", i), 0, upHi[i], WIN, 0);
      end
      fork
         measureNext();
         begin
            repeat (10) @(negedge clk);
            applyStimulus(2'b10, {7'd0, 7'd23});
         end
      join
      checkWin("ramp_up4_ch0", 0, upHi[4], WIN, 0);
      for (int i = 0; i < 5; i++) begin
         measureNext();
         checkWin($sformatf("ramp_down%0d_ch0", i), 0, downHi[i], WIN, 0);
      end
      for (int i = 0; i < DEADTIME; i++) begin
         measureNext();
         checkWin($sformatf("ramp_dead%0d_ch0", i), 0, 0, 0, 0);
      end
      measureNext();
      checkWin("ramp_reentry_ch0", 0, RAMP_STEP * PRESC, 0, WIN);
      checkWin("ramp_idle_ch1", 1, 0, 0, 0);
   endtask

   initial begin
      repeat (60000) @(posedge clk);
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [NUM_CH-1:0]        rs;
      logic [NUM_CH*DUTY_W-1:0] rc;
      int                       v;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checkOutput("reset_enable", int'(enable), 0);
      checkOutput("reset_in_a", int'(in_a), 0);
      checkOutput("reset_in_b", int'(in_b), 0);
      checkOutput("reset_period_start", int'(period_start), 0);
      $display("[TB] directed phase");
      if (RAMP) directedRamp();
      else directedBasic();
      applyStimulus(2'b00, {7'd100, 7'd40});
      waitPeriodStart();
      repeat (37) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midrun_reset_enable", int'(enable), 0);
      checkOutput("midrun_reset_in_a", int'(in_a), 0);
      checkOutput("midrun_reset_in_b", int'(in_b), 0);
      reset = 1'b0;
      waitPeriodStart(); measureNext();
      checkWin("after_reset_idle_ch0", 0, 0, 0, 0);
      checkWin("after_reset_idle_ch1", 1, 0, 0, 0);
      $display("[TB] random phase");
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 300)) @(negedge clk);
         rs = NUM_CH'($urandom);
         for (int ch = 0; ch < NUM_CH; ch++) begin
            case ($urandom_range(0, 5))
               0:       v = 0;
               1:       v = PERIOD;
               2:       v = 127;
               default: v = int'($urandom_range(1, 127));
            endcase
            rc[ch*DUTY_W +: DUTY_W] = DUTY_W'(v);
         end
         applyStimulus(rs, rc);
      end
      repeat (3 * WIN) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
